viterbi_decoder: RTL and testbench
==================================

VITERBI_DECODER -- requirements
Module: viterbi_decoder

Interface
REQ-001 Parameter TB_DEPTH, default 16, survivor length in decoded bits and the decode latency in accepted symbols; legal range 8..32.
REQ-002 Parameter PM_W, default 6, path-metric width in bits; legal range 5..8.
REQ-003 One clock; reset is asynchronous and active-low, ports named clk and reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  high when in holds a symbol to accept on this edge.
REQ-007 in  input  2  received hard-decision symbol; in[1] = G0 (octal 7) bit, in[0] = G1 (octal 5) bit.
REQ-008 out  output  1  decoded data bit, registered.
REQ-009 out_valid  output  1  high for one cycle per decoded bit, registered.

Function
REQ-010 Code SHALL be the K=3, rate-1/2 convolutional code matching the upstream encoder: state s={b[n-1],b[n-2]}; in[1]=b^s[1]^s[0]; in[0]=b^s[0]; next state {b,s[1]}; encoder starts in state 0.
REQ-011 Symbol accepted only on a rising edge with in_valid=1; with in_valid=0, metrics, survivors, counter and out SHALL hold, and out_valid SHALL be 0 next cycle.
REQ-012 Branch metric SHALL be the Hamming distance (0..2) between in and the expected symbol for each transition.
REQ-013 ACS: for next state ns={b,x}, candidates are predecessors {x,0} and {x,1}; select smaller PM+BM; on a tie, select predecessor with s[0]=0.
REQ-014 Normalization: after ACS, subtract the minimum of the four new metrics from all four, so the best metric is always 0 and no metric exceeds 2*(K-1)+2; arithmetic SHALL never wrap at PM_W.
REQ-015 Register exchange: new survivor[ns] = {survivor[pred][TB_DEPTH-2:0], b}; bit 0 = newest decision.
REQ-016 Best state = state with the minimum post-ACS metric; on a tie, lowest state index.
REQ-017 On the edge accepting symbol n (0-indexed since reset), out SHALL load bit TB_DEPTH-1 of the best state's new survivor, which is the decoded bit for symbol n-(TB_DEPTH-1).
REQ-018 out_valid SHALL be 1 in the cycle after accepting symbol n iff n >= TB_DEPTH-1; with TB_DEPTH=16, the first valid output follows the 16th accepted symbol.
REQ-019 Accepted-symbol counter SHALL saturate at TB_DEPTH-1, so streams of any length never re-enter warm-up.
REQ-020 Latency: one clock from the accepting edge to out/out_valid; throughput one symbol per clock, no back-pressure.

Reset
REQ-021 While reset=0: PM[0]=0, PM[1..3]=4, all survivors 0, counter 0, out=0, out_valid=0, independent of clk.
REQ-022 Reset asserted mid-stream SHALL discard all in-flight bits; after release, decoding restarts from encoder state 0 with a full TB_DEPTH warm-up.
REQ-023 First symbol SHALL be accepted on the first rising edge after reset deasserts with in_valid=1.

Verification
REQ-024 All-zero stream: 40 symbols of in=00, in_valid=1 -> out_valid low for the first 15 edges, then 25 pulses, all out=0, PM[0]=0 throughout.
REQ-025 Single 1 bit: data 1 then 0s; in=11,10,11, then 00 for 30 symbols -> first valid out=1, then all 0.
REQ-026 Encoder sequence 0101110010100010 plus 16 flush zeros, encoded per REQ-010 -> after warm-up, out reproduces the 16 data bits in order, then 0s.
REQ-027 Error correction: same stream with one flipped bit in symbol 5 -> decoded output identical to REQ-026.
REQ-028 in_valid gaps: REQ-026 stream with in_valid=0 on random cycles -> identical out sequence; out_valid never high after an idle edge.
REQ-029 Reset pulse mid-stream after 20 symbols -> out=0 and out_valid=0 immediately; fresh REQ-025 stream decodes correctly after release.

Source files
------------

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder for the K=3, rate-1/2 (7,5) convolutional code.
// Uses register-exchange survivors and outputs one decoded bit per accepted symbol after TB_DEPTH-1 symbols of warm-up.
module viterbi_decoder #(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [1:0] in,
    output logic       out,
    output logic       out_valid
);

    localparam int CNT_W = $clog2(TB_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TB_DEPTH - 1);

    logic [PM_W-1:0]     pm_p0   [4];
    logic [TB_DEPTH-1:0] surv_p0 [4];
    logic [CNT_W-1:0]    cnt_p0;

    logic [PM_W-1:0]     acs     [4];
    logic [PM_W-1:0]     pm_next [4];
    logic [TB_DEPTH-1:0] surv_next [4];
    logic [PM_W-1:0]     pm_min;
    logic [1:0]          best;

    function automatic logic [1:0] exp_sym(input logic b, input logic [1:0] s);
        return {b ^ s[1] ^ s[0], b ^ s[0]};
    endfunction

    function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] e);
        logic [1:0] d;
        d = a ^ e;
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

    // Saturating add keeps a metric from ever wrapping at PM_W.
    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm, input logic [1:0] bm);
        logic [PM_W:0] s;
        s = {1'b0, pm} + {{(PM_W - 1){1'b0}}, bm};
        return s[PM_W] ? {PM_W{1'b1}} : s[PM_W-1:0];
    endfunction

    always_comb begin
        for (int ns = 0; ns < 4; ns++) begin
            logic [1:0]      nsv;
            logic [1:0]      p0;
            logic [1:0]      p1;
            logic [PM_W-1:0] c0;
            logic [PM_W-1:0] c1;
            nsv = 2'(ns);
            p0  = {nsv[0], 1'b0};
            p1  = {nsv[0], 1'b1};
            c0  = sat_add(pm_p0[p0], hamming(in, exp_sym(nsv[1], p0)));
            c1  = sat_add(pm_p0[p1], hamming(in, exp_sym(nsv[1], p1)));
            // Ties favour the predecessor whose low state bit is 0.
            if (c1 < c0) begin
                acs[ns]       = c1;
                surv_next[ns] = {surv_p0[p1][TB_DEPTH-2:0], nsv[1]};
            end else begin
                acs[ns]       = c0;
                surv_next[ns] = {surv_p0[p0][TB_DEPTH-2:0], nsv[1]};
            end
        end

        pm_min = acs[0];
        best   = 2'd0;
        for (int s = 1; s < 4; s++) begin
            if (acs[s] < pm_min) begin
                pm_min = acs[s];
                best   = 2'(s);
            end
        end

        for (int s = 0; s < 4; s++) begin
            pm_next[s] = acs[s] - pm_min;
        end
    end

    // Stage p0: metrics, survivors, warm-up counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pm_p0[0] <= '0;
            for (int s = 1; s < 4; s++) pm_p0[s] <= PM_W'(4);
            for (int s = 0; s < 4; s++) surv_p0[s] <= '0;
            cnt_p0    <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid && (cnt_p0 == CNT_MAX);
            if (in_valid) begin
                for (int s = 0; s < 4; s++) begin
                    pm_p0[s]   <= pm_next[s];
                    surv_p0[s] <= surv_next[s];
                end
                out <= surv_next[best][TB_DEPTH-1];
                if (cnt_p0 != CNT_MAX) cnt_p0 <= cnt_p0 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Directed bench for viterbi_decoder: all-zero, single-one, encoded data, bit error, idle gaps and mid-stream reset.
module tb_viterbi_decoder;

    localparam int TB_DEPTH = 16;
    localparam int PM_W     = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [1:0] in;
    logic       out;
    logic       out_valid;

    int total = 0;
    int bad   = 0;

    logic [15:0] data_word;
    logic [1:0]  seq [32];
    logic [1:0]  one [33];

    always #5 clk = ~clk;

    viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in        (in),
        .out       (out),
        .out_valid (out_valid)
    );

    // Data bit i of the 16-bit test message (first bit is the MSB), zeros afterwards.
    function automatic logic data_bit(input int i);
        if (i < 0 || i > 15) return 1'b0;
        return data_word[15 - i];
    endfunction

    task automatic send(input logic v, input logic [1:0] sym, output logic o, output logic ov);
        @(negedge clk);
        in_valid = v;
        in       = sym;
        @(posedge clk);
        #1;
        o  = out;
        ov = out_valid;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        in_valid = 1'b0;
        in       = 2'b00;
        reset    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        in_valid = 1'b1;
        in       = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out !== 1'b0) begin bad++; $display("FAIL reset_out got=%b want=0", out); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++;
        if (dut.pm_p0[0] !== 6'd0) begin bad++; $display("FAIL reset_pm0 got=%0d want=0", dut.pm_p0[0]); end
        total++;
        if (dut.pm_p0[3] !== 6'd4) begin bad++; $display("FAIL reset_pm3 got=%0d want=4", dut.pm_p0[3]); end
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
    endtask

    task automatic test_all_zero();
        logic o, ov;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            send(1'b1, 2'b00, o, ov);
            total++;
            if (ov !== (i >= 15)) begin bad++; $display("FAIL zero_valid i=%0d got=%b want=%b", i, ov, (i >= 15)); end
            total++;
            if (o !== 1'b0) begin bad++; $display("FAIL zero_out i=%0d got=%b want=0", i, o); end
            total++;
            if (dut.pm_p0[0] !== 6'd0) begin bad++; $display("FAIL zero_pm0 i=%0d got=%0d want=0", i, dut.pm_p0[0]); end
        end
    endtask

    task automatic test_single_one();
        logic o, ov;
        apply_reset();
        for (int i = 0; i < 33; i++) begin
            send(1'b1, one[i], o, ov);
            total++;
            if (ov !== (i >= 15)) begin bad++; $display("FAIL one_valid i=%0d got=%b want=%b", i, ov, (i >= 15)); end
            total++;
            if (o !== (i == 15)) begin bad++; $display("FAIL one_out i=%0d got=%b want=%b", i, o, (i == 15)); end
        end
    endtask

    task automatic test_sequence();
        logic o, ov;
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            send(1'b1, seq[i], o, ov);
            total++;
            if (ov !== (i >= 15)) begin bad++; $display("FAIL seq_valid i=%0d got=%b want=%b", i, ov, (i >= 15)); end
            total++;
            if (o !== data_bit(i - 15)) begin bad++; $display("FAIL seq_out i=%0d got=%b want=%b", i, o, data_bit(i - 15)); end
        end
    endtask

    task automatic test_bit_error();
        logic o, ov;
        logic [1:0] sym;
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            sym = (i == 5) ? (seq[i] ^ 2'b10) : seq[i];
            send(1'b1, sym, o, ov);
            total++;
            if (ov !== (i >= 15)) begin bad++; $display("FAIL err_valid i=%0d got=%b want=%b", i, ov, (i >= 15)); end
            total++;
            if (o !== data_bit(i - 15)) begin bad++; $display("FAIL err_out i=%0d got=%b want=%b", i, o, data_bit(i - 15)); end
        end
    endtask

    task automatic test_gaps();
        logic o, ov;
        logic exp_out;
        logic [31:0] idle_mask;
        idle_mask = 32'h0206_8A24;
        exp_out   = 1'b0;
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            if (idle_mask[i]) begin
                for (int k = 0; k <= (i % 2); k++) begin
                    send(1'b0, 2'(i + k), o, ov);
                    total++;
                    if (ov !== 1'b0) begin bad++; $display("FAIL gap_idle_valid i=%0d got=%b want=0", i, ov); end
                    total++;
                    if (o !== exp_out) begin bad++; $display("FAIL gap_idle_hold i=%0d got=%b want=%b", i, o, exp_out); end
                end
            end
            send(1'b1, seq[i], o, ov);
            exp_out = data_bit(i - 15);
            total++;
            if (ov !== (i >= 15)) begin bad++; $display("FAIL gap_valid i=%0d got=%b want=%b", i, ov, (i >= 15)); end
            total++;
            if (o !== exp_out) begin bad++; $display("FAIL gap_out i=%0d got=%b want=%b", i, o, exp_out); end
        end
    endtask

    task automatic test_reset_mid();
        logic o, ov;
        apply_reset();
        for (int i = 0; i < 20; i++) send(1'b1, seq[i], o, ov);
        total++;
        if (ov !== 1'b1 || o !== data_bit(4)) begin
            bad++; $display("FAIL mid_pre out=%b valid=%b want out=%b valid=1", o, ov, data_bit(4));
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if (out !== 1'b0) begin bad++; $display("FAIL mid_reset_out got=%b want=0", out); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%b want=0", out_valid); end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 33; i++) begin
            send(1'b1, one[i], o, ov);
            total++;
            if (ov !== (i >= 15)) begin bad++; $display("FAIL mid_valid i=%0d got=%b want=%b", i, ov, (i >= 15)); end
            total++;
            if (o !== (i == 15)) begin bad++; $display("FAIL mid_out i=%0d got=%b want=%b", i, o, (i == 15)); end
        end
    endtask

    initial begin
        logic [1:0] s;
        logic       b;
        data_word = 16'b0101110010100010;
        s = 2'b00;
        for (int i = 0; i < 32; i++) begin
            b      = data_bit(i);
            seq[i] = {b ^ s[1] ^ s[0], b ^ s[0]};
            s      = {b, s[1]};
        end
        for (int i = 0; i < 33; i++) one[i] = 2'b00;
        one[0] = 2'b11;
        one[1] = 2'b10;
        one[2] = 2'b11;

        test_reset();
        test_all_zero();
        test_single_one();
        test_sequence();
        test_bit_error();
        test_gaps();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
